// File: rtl/aui_am_lock.sv
// Alignment-marker lock for one 257-bit AUI flow.
// Searches for the AM block, verifies its period and tags passing blocks.
module aui_am_lock #(
    parameter int BITS_BLOCK    = 257,
    parameter int MAX_BLOCKS_AM = 40,
    parameter int LOCK_CNT      = 3,
    parameter int UNLOCK_CNT    = 4,
    parameter int MAX_BIT_ERR   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BITS_BLOCK-1:0]               i_flow,
    input  logic                                i_valid,
    input  logic [BITS_BLOCK-1:0]               i_am_ref,
    input  logic [BITS_BLOCK-1:0]               i_am_mask,
    output logic [BITS_BLOCK-1:0]               o_flow,
    output logic                                o_valid,
    output logic [$clog2(MAX_BLOCKS_AM)-1:0]    o_block_idx,
    output logic                                o_am_start,
    output logic                                o_lock,
    output logic [$clog2(BITS_BLOCK+1)-1:0]     o_bit_err
);

    localparam int IDX_W  = $clog2(MAX_BLOCKS_AM);
    localparam int ERR_W  = $clog2(BITS_BLOCK + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic [GOOD_W-1:0]   good_cnt;
    logic [GOOD_W-1:0]   good_inc;
    logic [BAD_W-1:0]    bad_cnt;
    logic [BAD_W-1:0]    bad_inc;
    logic [BITS_BLOCK-1:0] diff;
    logic [ERR_W-1:0]    err;
    logic                match;
    logic                at_am;

    always_comb begin
        diff = (i_flow ^ i_am_ref) & i_am_mask;
        err  = '0;
        for (int i = 0; i < BITS_BLOCK; i++) begin
            err = err + ERR_W'(diff[i]);
        end
    end

    assign match    = (err <= ERR_W'(MAX_BIT_ERR));
    assign at_am    = (idx == '0);
    assign idx_inc  = (idx == IDX_W'(MAX_BLOCKS_AM - 1)) ? '0 : idx + IDX_W'(1);
    assign good_inc = good_cnt + GOOD_W'(1);
    assign bad_inc  = bad_cnt + BAD_W'(1);

    // idx is the period position the next valid block will take
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            idx         <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            o_flow      <= '0;
            o_valid     <= 1'b0;
            o_block_idx <= '0;
            o_am_start  <= 1'b0;
            o_lock      <= 1'b0;
            o_bit_err   <= '0;
        end else begin
            o_valid    <= i_valid;
            o_am_start <= 1'b0;
            if (i_valid) begin
                o_flow      <= i_flow;
                o_block_idx <= idx;
                idx         <= idx_inc;
                unique case (state)
                    SEARCH: begin
                        o_bit_err <= err;
                        if (match) begin
                            idx         <= IDX_W'(1 % MAX_BLOCKS_AM);
                            o_block_idx <= '0;
                            good_cnt    <= GOOD_W'(1);
                            if (LOCK_CNT == 1) begin
                                state      <= LOCKED;
                                o_lock     <= 1'b1;
                                o_am_start <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (at_am) begin
                            o_bit_err <= err;
                            if (match) begin
                                good_cnt <= good_inc;
                                if (good_inc == GOOD_W'(LOCK_CNT)) begin
                                    state      <= LOCKED;
                                    o_lock     <= 1'b1;
                                    o_am_start <= 1'b1;
                                end
                            end else begin
                                state    <= SEARCH;
                                good_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        o_am_start <= at_am;
                        if (at_am) begin
                            o_bit_err <= err;
                            if (match) begin
                                bad_cnt <= '0;
                            end else if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                                state      <= SEARCH;
                                o_lock     <= 1'b0;
                                o_am_start <= 1'b0;
                                bad_cnt    <= '0;
                                good_cnt   <= '0;
                            end else begin
                                bad_cnt <= bad_inc;
                            end
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                        o_lock   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aui_am_lock.sv
// Scoreboard bench for aui_am_lock: directed AM streams with
// expectations derived from the AM position in each stream.
module tb_aui_am_lock;

    localparam int W = 257;

    typedef struct packed {
        logic [W-1:0] flow;
        logic         lock;
        logic         start;
        logic [5:0]   idx;
        logic [8:0]   err;
        logic         err_chk;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] i_flow;
    logic         i_valid;
    logic [W-1:0] am_ref;
    logic [W-1:0] am_mask;
    logic [W-1:0] o_flow;
    logic         o_valid;
    logic [5:0]   o_block_idx;
    logic         o_am_start;
    logic         o_lock;
    logic [8:0]   o_bit_err;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    logic         iv_q;
    logic [W-1:0] last_flow;

    aui_am_lock dut (
        .clk        (clk),
        .rst        (rst),
        .i_flow     (i_flow),
        .i_valid    (i_valid),
        .i_am_ref   (am_ref),
        .i_am_mask  (am_mask),
        .o_flow     (o_flow),
        .o_valid    (o_valid),
        .o_block_idx(o_block_idx),
        .o_am_start (o_am_start),
        .o_lock     (o_lock),
        .o_bit_err  (o_bit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd257();
        logic [287:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] lowbits(input int n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero();
        chk("rst_o_flow", o_flow, '0);
        chk("rst_o_valid", W'(o_valid), '0);
        chk("rst_o_block_idx", W'(o_block_idx), '0);
        chk("rst_o_am_start", W'(o_am_start), '0);
        chk("rst_o_lock", W'(o_lock), '0);
        chk("rst_o_bit_err", W'(o_bit_err), '0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) iv_q <= 1'b0;
        else      iv_q <= i_valid;
    end

    // Monitor: pops one expectation per presented block
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("o_valid", W'(o_valid), W'(iv_q));
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got block %h want none", o_flow);
                end else begin
                    e = sb.pop_front();
                    chk("o_flow", o_flow, e.flow);
                    chk("o_lock", W'(o_lock), W'(e.lock));
                    chk("o_am_start", W'(o_am_start), W'(e.start));
                    if (e.lock) chk("o_block_idx", W'(o_block_idx), W'(e.idx));
                    if (e.err_chk) chk("o_bit_err", W'(o_bit_err), W'(e.err));
                    last_flow = e.flow;
                end
            end else begin
                chk("idle_am_start", W'(o_am_start), '0);
                chk("idle_flow_hold", o_flow, last_flow);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
        i_flow  = rnd257();
    endtask

    task automatic put(input logic [W-1:0] f, input exp_t e, input bit tog);
        if (tog) repeat ($urandom_range(0, 2)) idle();
        @(negedge clk);
        i_flow  = f;
        i_valid = 1'b1;
        sb.push_back(e);
    endtask

    // mode 0 clean, 1 AM errors + loss, 2 verify failure, 3 masked bits
    task automatic stream(input int mode, input int pre, input int n,
                          input bit tog);
        exp_t e;
        logic [W-1:0] f;
        logic [W-1:0] topb;
        int flips;
        bit am;
        bit lk;
        flips = 0;
        topb = '0;
        topb[W-1:W-3] = 3'b111;
        for (int k = 0; k < pre; k++) begin
            e = '0;
            f = rnd257();
            e.flow = f;
            put(f, e, tog);
        end
        for (int j = 0; j < n; j++) begin
            am = (j % 40 == 0);
            if (am) begin
                flips = 0;
                if (mode == 1) begin
                    if (j == 200) flips = 3;
                    else if (j == 240 || j == 320 || j == 360 ||
                             j == 400 || j == 440) flips = 4;
                end else if (mode == 2 && j == 40) begin
                    flips = 4;
                end
            end
            if (!am)            f = rnd257();
            else if (mode == 3) f = am_ref ^ topb;
            else                f = am_ref ^ lowbits(flips);
            if (mode == 1)      lk = (j >= 80 && j < 440) || j >= 560;
            else if (mode == 2) lk = (j >= 160);
            else                lk = (j >= 80);
            e = '0;
            e.flow    = f;
            e.lock    = lk;
            e.start   = lk && am;
            e.idx     = 6'(j % 40);
            e.err     = 9'(flips);
            e.err_chk = am || lk;
            put(f, e, tog);
        end
        idle();
    endtask

    task automatic do_reset(input bit mid);
        @(negedge clk);
        if (mid) chk("pre_rst_lock", W'(o_lock), W'(1));
        #2;
        rst     = 1'b0;
        i_valid = 1'b0;
        sb.delete();
        last_flow = '0;
        #1;
        chk_zero();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        i_valid   = 1'b0;
        i_flow    = '0;
        last_flow = '0;
        am_ref    = rnd257();
        am_mask   = '1;
        #12;
        chk_zero();
        @(negedge clk);
        #2;
        rst = 1'b1;

        stream(1, 7, 600, 1'b0);
        do_reset(1'b0);
        stream(2, 3, 200, 1'b0);
        do_reset(1'b0);
        stream(0, 5, 130, 1'b1);
        do_reset(1'b1);
        stream(0, 11, 130, 1'b0);
        do_reset(1'b0);
        am_mask[W-1:W-3] = 3'b000;
        stream(3, 2, 130, 1'b0);

        repeat (3) idle();
        chk("sb_drained", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aui_am_lock.md
# aui_am_lock

Receive-side alignment-marker lock for the 257-bit AUI flows produced by the AUI generator (one instance per flow). Finds the AM block in the incoming 257-bit block stream and confirms its period of MAX_BLOCKS_AM blocks. Declares lock, or loss of lock, using hysteresis counters. Passes data through with one cycle of latency, tagging each block with its position in the AM period.

## Interface
- BITS_BLOCK, 257, block width in bits.
- MAX_BLOCKS_AM, 40, AM period in blocks; block 0 of each period is the AM block.
- LOCK_CNT, 3, consecutive good AM checks required to lock (≥1).
- UNLOCK_CNT, 4, consecutive bad AM checks while locked that drop lock (≥1).
- MAX_BIT_ERR, 3, maximum masked bit mismatches for a block to count as a match.

Ports:
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-low reset.
- i_flow  in  BITS_BLOCK  incoming block (bit 0 = first bit, same layout as generator o_flow_x).
- i_valid  in  1  i_flow is valid this cycle.
- i_am_ref  in  BITS_BLOCK  expected AM block 0 contents; quasi-static.
- i_am_mask  in  BITS_BLOCK  1 = compare this bit; 0 = ignore it (status/PRBS bits).
- o_flow  out  BITS_BLOCK  registered copy of i_flow.
- o_valid  out  1  registered i_valid.
- o_block_idx  out  $clog2(MAX_BLOCKS_AM)  position of o_flow in the AM period; meaningful only while o_lock=1.
- o_am_start  out  1  o_flow is the AM block (idx 0) and o_lock=1.
- o_lock  out  1  alignment locked.
- o_bit_err  out  $clog2(BITS_BLOCK+1)  masked mismatch count of the last checked block.

## Operation
- Per valid block, compute err = popcount((i_flow ^ i_am_ref) & i_am_mask). match = (err ≤ MAX_BIT_ERR). The popcount is combinational within the cycle; err is unsigned and saturates at nothing (max 257 fits 9 bits).
- A "check" is a valid block evaluated against the AM:
  - in SEARCH, every valid block is a check;
  - otherwise, only a valid block with idx == 0 is a check.
- idx counter:
  - Advances by one per valid block and wraps from MAX_BLOCKS_AM-1 to 0.
  - On a SEARCH match, idx is set so that this block is idx 0; the next valid block is idx 1.
  - i_valid=0: all counters and state hold.
- States:
  - SEARCH: good_cnt=0, bad_cnt=0, o_lock=0. On a match, set good_cnt=1. If LOCK_CNT==1, go to LOCKED; else go to VERIFY. On a mismatch, stay (slip by one block).
  - VERIFY: on a check match, good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED. On a check mismatch, go to SEARCH. The mismatching block itself is not re-searched; search resumes on the next valid block.
  - LOCKED: on a check match, bad_cnt=0. On a check mismatch, bad_cnt++. When bad_cnt reaches UNLOCK_CNT, go to SEARCH, and o_lock falls with that block.
- o_bit_err updates only on checks and otherwise holds.
- o_am_start and o_block_idx reflect the state after the block's own check. The block that completes lock carries o_lock=1 and o_am_start=1.
- i_am_ref and i_am_mask changes take effect on the next check; no state reset results.

## Timing
- Latency is 1 cycle: o_flow/o_valid/o_block_idx/o_am_start/o_lock/o_bit_err all correspond to the i_flow of the previous valid cycle.
- All outputs are registered. While i_valid=0, o_valid=0, o_flow holds, and o_am_start=0.
- Reset (rst low, asynchronous):
  - state=SEARCH, idx=0, good_cnt=0, bad_cnt=0;
  - o_flow=0, o_valid=0, o_block_idx=0, o_am_start=0, o_lock=0, o_bit_err=0.
- Reset asserted mid-lock clears immediately without waiting for a clock edge. Operation restarts from SEARCH on the first clk after release.
- Simultaneous match and counter terminal: the state transition and the output tagging happen in the same cycle.
- Lock is acquired no earlier than (LOCK_CNT-1)*MAX_BLOCKS_AM valid blocks after the first AM seen. Lock is lost exactly at the UNLOCK_CNT-th consecutive bad AM.

## Test plan
- Clean generator stream, ref = AM block 0, full mask: o_lock rises with the 3rd AM (valid block 80 after the first AM). From then on, o_am_start pulses every 40 valid blocks and o_block_idx runs 0..39.
- Lock held, then 3 bits flipped in an AM block: match, o_bit_err=3, lock kept. Then 4 bits flipped: o_bit_err=4, bad_cnt=1, lock kept. Then four consecutive corrupted AMs: o_lock falls on the 4th.
- VERIFY with the 2nd AM corrupted: return to SEARCH, no lock. Lock then occurs 80 blocks after the next clean AM.
- i_valid toggled 1/0 randomly over a clean stream: lock is acquired with idx counting only valid blocks; o_valid mirrors i_valid delayed by 1 cycle.
- rst pulsed low while locked, between clock edges: all outputs are 0 immediately. After release, re-lock takes 3 AMs.
- Mask with bits [256:254]=0 and those bits differing in the stream: err=0 and lock is acquired normally.
